// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces active-low push buttons, producing a
// registered pressed level plus one-cycle press, release and long-press pulses per key.
module key_debounce #(
  parameter int unsigned KEY_NUM         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_n,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  // Guard the widths so a parameter of 2 still yields a usable 1-bit counter.
  localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HoldW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [CntW-1:0]  CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  // Two-flop synchronizer; sync2_q is the synchronized key_s level (0 = pressed).
  logic [KEY_NUM-1:0] sync1_q;
  logic [KEY_NUM-1:0] sync2_q;

  state_e           state_q [KEY_NUM];
  state_e           state_d [KEY_NUM];
  logic [CntW-1:0]  cnt_q   [KEY_NUM];
  logic [CntW-1:0]  cnt_d   [KEY_NUM];
  logic [HoldW-1:0] hold_q  [KEY_NUM];
  logic [HoldW-1:0] hold_d  [KEY_NUM];

  logic [KEY_NUM-1:0] fired_q, fired_d;
  logic [KEY_NUM-1:0] level_q, level_d;
  logic [KEY_NUM-1:0] press_q, press_d;
  logic [KEY_NUM-1:0] release_q, release_d;
  logic [KEY_NUM-1:0] long_q, long_d;

  // Synchronizer flops reset to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Per-key FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
      end
      fired_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
      end
      fired_q   <= fired_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // Next-state and next-output logic, evaluated independently for every key.
  always_comb begin
    fired_d   = fired_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hold_d[i]  = hold_q[i];

      case (state_q[i])
        StIdle: begin
          if (!sync2_q[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = '0;
          end
        end

        StPressWait: begin
          if (sync2_q[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StPressed;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
            hold_d[i]  = '0;
            fired_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end

        StPressed: begin
          if (sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = '0;
          end else if (hold_q[i] == HoldMax && !fired_q[i]) begin
            long_d[i]  = 1'b1;
            fired_d[i] = 1'b1;
          end else if (hold_q[i] != HoldMax) begin
            hold_d[i] = hold_q[i] + HoldW'(1);
          end
        end

        StReleaseWait: begin
          // A bounce back to pressed keeps hold and the fired flag, so one
          // physical press can never produce two long pulses.
          if (!sync2_q[i]) begin
            state_d[i] = StPressed;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i]   = StIdle;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end

        default: begin
          state_d[i] = StIdle;
        end
      endcase
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule
